// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous serial/handshake line.
// Both flops reset to RST_VAL so the line reads as idle out of reset.
module uart_sync
  import uart_pkg::*;
#(
  parameter logic RST_VAL = UART_IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the async input, then retime it once more before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-byte holding register,
// valid/ready handoff, rts flow control and framing/overrun pulses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for a low level on rxd_s
// START | counting to mid start bit, re-checking it is still low
// DATA  | sampling 8 data bits LSB first, one per BIT_CLK cycles
// STOP  | counting to mid stop bit, then deliver / overrun / error
// BREAK | stop bit was low; wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CLK = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rts,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = BIT_CLK / 2;
  localparam int CW   = $clog2(BIT_CLK);

  localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CLK - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  uart_rx_state_t            state_nxt;
  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] sh;
  logic                      rxd_s;

  logic cnt_zero;
  logic load_byte;
  logic ovr_set;
  logic fe_set;
  logic rx_valid_nxt;

  uart_sync #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  assign cnt_zero = (cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; every bit-period decision happens when cnt hits zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rxd_s) state_nxt = START;
      START:   if (cnt_zero) state_nxt = rxd_s ? IDLE : DATA;
      DATA:    if (cnt_zero && (idx == IDX_LAST)) state_nxt = STOP;
      STOP:    if (cnt_zero) state_nxt = rxd_s ? IDLE : BREAK;
      BREAK:   if (rxd_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: stop-sample outcomes and the next holding-register flag.
  always_comb begin
    busy         = (state != IDLE);
    load_byte    = 1'b0;
    ovr_set      = 1'b0;
    fe_set       = 1'b0;
    if (state == STOP && cnt_zero) begin
      if (!rxd_s)                     fe_set    = 1'b1;
      else if (!rx_valid || rx_ready) load_byte = 1'b1;
      else                            ovr_set   = 1'b1;
    end
    // A byte landing on the same edge it is consumed keeps valid high.
    if (load_byte)                 rx_valid_nxt = 1'b1;
    else if (rx_valid && rx_ready) rx_valid_nxt = 1'b0;
    else                           rx_valid_nxt = rx_valid;
  end

  // Bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) cnt <= CNT_HALF;
        end
        START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (!rxd_s) begin
            cnt <= CNT_BIT;
            idx <= '0;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            sh  <= {rxd_s, sh[UART_DATA_BITS-1:1]};
            cnt <= CNT_BIT;
            if (idx != IDX_LAST) idx <= idx + 3'd1;
          end
        end
        STOP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Holding register, flow control and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rts       <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_valid  <= rx_valid_nxt;
      rts       <= !rx_valid_nxt;
      frame_err <= fe_set;
      overrun   <= ovr_set;
      if (load_byte) rx_data <= sh;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized
// frame sequence checked against a holding-register model.
module tb_uart_rx;

  localparam int BIT_CLK = 8;
  localparam int HALF    = BIT_CLK / 2;
  localparam int LAT     = 2 + HALF + 9 * BIT_CLK;  // start edge to stop-sample edge

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rts;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;

  uart_rx #(.BIT_CLK(BIT_CLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rts       (rts),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Return 1 time unit after posedge number n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame starting at the current negedge; ends on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    total++; if (rts !== 1'b1) begin bad++; $display("FAIL reset_rts: got %b want 1", rts); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", frame_err, overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int e;
    rx_ready = 1'b1;
    e = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_edge(e + 3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_edge(e + LAT - 1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL single_early: got valid=%b want 0", rx_valid); end
        wait_edge(e + LAT);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin bad++; $display("FAIL single_load: got valid=%b data=%h want 1 a5", rx_valid, rx_data); end
        total++; if (rts !== 1'b0) begin bad++; $display("FAIL single_rts_low: got %b want 0", rts); end
        wait_edge(e + LAT + 1);
        total++; if (rx_valid !== 1'b0 || rts !== 1'b1) begin bad++; $display("FAIL single_consume: got valid=%b rts=%b want 0 1", rx_valid, rts); end
      end
    join
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun;
    int e1, e2, ov0;
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    e1 = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_edge(e1 + LAT);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hFF || rts !== 1'b0) begin bad++; $display("FAIL ovr_first: got valid=%b data=%h rts=%b want 1 ff 0", rx_valid, rx_data, rts); end
      end
    join
    e2 = cyc + 1;
    fork
      send_frame(8'h33, 1'b1);
      begin
        wait_edge(e2 + LAT);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        total++; if (rx_data !== 8'hFF || rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_keep: got data=%h valid=%b want ff 1", rx_data, rx_valid); end
        wait_edge(e2 + LAT + 1);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_width: got %b want 0", overrun); end
      end
    join
    total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", ov_cnt - ov0); end
    rx_ready = 1'b1;
    wait_edge(cyc + 1);
    total++; if (rx_valid !== 1'b0 || rts !== 1'b1) begin bad++; $display("FAIL ovr_drain: got valid=%b rts=%b want 0 1", rx_valid, rts); end
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_glitch;
    int e, fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    e = cyc + 1;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    wait_edge(e + 3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_start: got busy=%b want 1", busy); end
    wait_edge(e + 2 + HALF + 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: got busy=%b want 0", busy); end
    repeat (LAT) @(negedge clk);
    total++; if (rx_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin bad++; $display("FAIL glitch_quiet: got valid=%b fe=%0d ov=%0d want 0 0 0", rx_valid, fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_frame_err;
    int e, fe0, idle_seen;
    fe0 = fe_cnt;
    rx_ready = 1'b1;
    e = cyc + 1;
    fork
      send_frame(8'h55, 1'b0);
      begin
        wait_edge(e + LAT);
        total++; if (frame_err !== 1'b1 || overrun !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL fe_pulse: got fe=%b ov=%b valid=%b want 1 0 0", frame_err, overrun, rx_valid); end
        wait_edge(e + LAT + 1);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL fe_width: got %b want 0", frame_err); end
      end
    join
    idle_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b1) idle_seen++;
    end
    total++; if (idle_seen != 0) begin bad++; $display("FAIL fe_break_busy: got %0d idle cycles want 0", idle_seen); end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fe_release: got busy=%b want 0", busy); end
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL fe_count: got %0d want 1", fe_cnt - fe0); end
    e = cyc + 1;
    fork
      send_frame(8'hAA, 1'b1);
      begin
        wait_edge(e + LAT);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hAA) begin bad++; $display("FAIL fe_recover: got valid=%b data=%h want 1 aa", rx_valid, rx_data); end
      end
    join
    rx_ready = 1'b0;
  endtask

  task automatic test_rst_mid;
    int e;
    rx_ready = 1'b0;
    e = cyc + 1;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_edge(e + LAT);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin bad++; $display("FAIL rst_prefill: got valid=%b data=%h want 1 5a", rx_valid, rx_data); end
      end
    join
    rxd = 1'b0;
    repeat (BIT_CLK * 5 + HALF) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_midframe: got busy=%b want 1", busy); end
    rst = 1'b1;
    rxd = 1'b1;
    wait_edge(cyc + 1);
    total++; if (busy !== 1'b0 || rx_valid !== 1'b0 || rts !== 1'b1 || rx_data !== 8'h00) begin bad++; $display("FAIL rst_clear: got busy=%b valid=%b rts=%b data=%h want 0 0 1 00", busy, rx_valid, rts, rx_data); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_ready = 1'b1;
    e = cyc + 1;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        wait_edge(e + LAT);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin bad++; $display("FAIL rst_next_frame: got valid=%b data=%h want 1 3c", rx_valid, rx_data); end
      end
    join
    rx_ready = 1'b0;
  endtask

  task automatic test_simul;
    int e, ov0;
    rx_ready = 1'b0;
    e = cyc + 1;
    send_frame(8'h11, 1'b1);
    ov0 = ov_cnt;
    e = cyc + 1;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_edge(e + LAT - 1);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin bad++; $display("FAIL simul_pending: got valid=%b data=%h want 1 11", rx_valid, rx_data); end
        @(negedge clk);
        rx_ready = 1'b1;
        wait_edge(e + LAT);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h22 || overrun !== 1'b0 || rts !== 1'b0) begin bad++; $display("FAIL simul_load: got valid=%b data=%h ov=%b rts=%b want 1 22 0 0", rx_valid, rx_data, overrun, rts); end
        @(negedge clk);
        rx_ready = 1'b0;
        wait_edge(e + LAT + 1);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin bad++; $display("FAIL simul_hold: got valid=%b data=%h want 1 22", rx_valid, rx_data); end
      end
    join
    total++; if (ov_cnt != ov0) begin bad++; $display("FAIL simul_no_overrun: got %0d want 0", ov_cnt - ov0); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Model: a one-entry holding register; a good frame fills it if empty,
  // otherwise it is dropped as an overrun; a bad stop bit only flags an error.
  task automatic test_random;
    logic       m_valid;
    logic [7:0] m_data;
    logic [7:0] b;
    logic       good, consume, exp_fe, exp_ov;
    int e;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    m_data  = 8'h00;
    for (int n = 0; n < 12; n++) begin
      b       = 8'($urandom);
      good    = ($urandom_range(0, 3) != 0);
      consume = 1'($urandom_range(0, 1));
      if (consume) begin
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        m_valid = 1'b0;
      end
      @(negedge clk);
      exp_fe = !good;
      exp_ov = good && m_valid;
      if (good && !m_valid) begin
        m_valid = 1'b1;
        m_data  = b;
      end
      e = cyc + 1;
      fork
        send_frame(b, good);
        begin
          wait_edge(e + LAT);
          total++; if (rx_valid !== m_valid || rx_data !== m_data || rts !== !m_valid) begin bad++; $display("FAIL rand_hold[%0d]: got valid=%b data=%h rts=%b want %b %h %b", n, rx_valid, rx_data, rts, m_valid, m_data, !m_valid); end
          total++; if (frame_err !== exp_fe || overrun !== exp_ov) begin bad++; $display("FAIL rand_flags[%0d]: got fe=%b ov=%b want %b %b", n, frame_err, overrun, exp_fe, exp_ov); end
        end
      join
      if (!good) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_rst_mid();
    test_simul();
    test_random();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL fe_ov_exclusive: got %0d coincident cycles want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone oversampling UART receiver: the far end of the `uart_core` transmit path (`txd`/`cts`). It deserialises 8N1 frames from `rxd`, holds one received byte behind a valid/ready handshake, and drives `rts` so a `uart_core` transmitter wired to it through `cts` stops sending while the holding register is full. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `BIT_CLK`, default 8: `clk` cycles per serial bit. Must be ≥ 4. `HALF = BIT_CLK/2` (integer division).
- `clk` in, 1: single clock; all logic is rising-edge.
- `rst` in, 1: synchronous, active-high reset.
- `rxd` in, 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` out, 8: held byte; reset `8'h00`.
- `rx_valid` out, 1: `rx_data` holds an unconsumed byte; reset 0.
- `rx_ready` in, 1: consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `rts` out, 1: high = able to receive; registered, equals `!rx_valid`; reset 1.
- `frame_err` out, 1: one-cycle pulse, stop bit sampled low; reset 0.
- `overrun` out, 1: one-cycle pulse, good frame dropped because the holding register was full; reset 0.
- `busy` out, 1: FSM not in IDLE; reset 0.

## Operation
- `rxd` passes through a 2-flop synchronizer (both flops reset to 1) to give `rxd_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK. Down-counter `cnt` has width `$clog2(BIT_CLK)`. Bit index `idx` is 0..7. Shift register `sh` is 8 bits.
- IDLE: if `rxd_s == 0`, go to START and set `cnt <= HALF-1`.
- START: decrement `cnt`. At `cnt == 0`:
  - `rxd_s == 0`: go to DATA, `cnt <= BIT_CLK-1`, `idx <= 0`.
  - otherwise: glitch; return to IDLE with no outputs.
- DATA: decrement `cnt`. At `cnt == 0`, `sh <= {rxd_s, sh[7:1]}` (LSB first) and `cnt <= BIT_CLK-1`. After `idx == 7` go to STOP; otherwise `idx++`.
- STOP: at `cnt == 0`:
  - `rxd_s == 1` and (`!rx_valid` or `rx_ready`): `rx_data <= sh`, `rx_valid <= 1`, go to IDLE.
  - `rxd_s == 1` and `rx_valid && !rx_ready`: pulse `overrun`, keep old `rx_data`, go to IDLE.
  - `rxd_s == 0`: pulse `frame_err`, discard `sh`, go to BREAK.
- BREAK: stay until `rxd_s == 1`, then go to IDLE. No new start is detected while in BREAK.
- Handshake:
  - `rx_valid` clears on the edge where `rx_valid && rx_ready`, unless a new byte loads on that same edge, in which case `rx_valid` stays 1 and `rx_data` updates.
  - `rx_data` is stable while `rx_valid && !rx_ready`.
- `rts <= !next_rx_valid`, registered alongside `rx_valid`.
- Reset mid-frame: FSM returns to IDLE, `sh`/`cnt`/`idx` are cleared, the holding register is emptied, and all outputs take their reset values on the next edge.

## Timing
- Let edge E be the first edge at which synchronizer flop 1 captures `rxd` low.
  - `rxd_s` is low after E+1.
  - IDLE→START at E+2.
  - Start bit checked at E+2+HALF.
  - Data bit i sampled at E+2+HALF+(i+1)·BIT_CLK.
  - Stop bit sampled at E+2+HALF+9·BIT_CLK.
- `rx_valid`, `rts`, `frame_err` and `overrun` change on the stop-sample edge. For BIT_CLK=8 this is E+78.
- A low pulse shorter than about HALF cycles on `rxd` is rejected as a glitch.
- Back-to-back frames: a start edge arriving immediately after the stop bit is accepted. The FSM returns to IDLE mid-stop-bit, giving HALF cycles of slack.
- `frame_err` and `overrun` are never asserted together. Each lasts exactly one cycle.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`
  - `localparam int UART_DATA_BITS = 8`
  - `localparam logic UART_IDLE_LEVEL = 1'b1`
- Sub-module `uart_sync`: 2-flop synchronizer with reset value parameter `RST_VAL` (default 1). Reusable for `cts` on the transmit side.
- All remaining logic (FSM, counter, shifter, holding register) lives in `uart_rx`.

## Test plan
- Frame `8'hA5` (8N1, BIT_CLK=8) with `rx_ready = 1`: `rx_valid` pulses 1 cycle at E+78 with `rx_data == 8'hA5`, and `rts` drops for that cycle.
- Frames `8'hFF` then `8'h33` back-to-back with `rx_ready = 0`:
  - after frame 1: `rx_data == 8'hFF`, `rx_valid = 1`, `rts = 0`;
  - after frame 2: one `overrun` pulse, `rx_data` still `8'hFF`;
  - then raise `rx_ready`: `rx_valid = 0` next cycle and `rts = 1`.
- `rxd` low for 2 cycles only: FSM returns to IDLE; `rx_valid`, `frame_err` and `overrun` stay 0.
- Frame `8'h55` with stop bit 0, line held low 20 more cycles, then a valid `8'hAA` frame:
  - one `frame_err` pulse;
  - `busy` stays 1 until the line goes high;
  - `8'hAA` is received correctly.
- `rst` asserted at data bit 4 of a frame: next cycle `busy = 0`, `rx_valid = 0`, `rts = 1`. The following frame `8'h3C` is received correctly.
- Stop sample coincides with `rx_valid && rx_ready` for the previous byte: new byte loads, `rx_valid` stays 1, no `overrun`.
